// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared size/state encodings and helpers for the load/store
//             sequencer and its request checker.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Number of memory beats for a size code; zero marks the illegal code.
    function automatic logic [2:0] nbytes(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ls_req_check.sv
`default_nettype none
// ============================================================================
//  Module   : ls_req_check
//  Purpose  : Combinational legality check of a load/store request: size
//             code, natural alignment and memory range.
//  Revision : 1.0  initial release
// ============================================================================
module ls_req_check
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = 32
) (
    input  logic [1:0]        i_size,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_legal,
    output logic [2:0]        o_nbytes
);

    localparam logic [ADDR_W:0] c_mem_limit = (ADDR_W+1)'(MEM_BYTES);

    logic [2:0]      w_nbytes;
    logic [ADDR_W:0] w_end;
    logic            w_aligned;
    logic            w_in_range;

    always_comb begin
        w_nbytes = nbytes(i_size);
        // One past the last byte touched; the extra bit keeps top-of-space
        // addresses from wrapping back into range.
        w_end    = {1'b0, i_addr} + {{(ADDR_W-2){1'b0}}, w_nbytes};

        case (i_size)
            SZ_BYTE: w_aligned = 1'b1;
            SZ_HALF: w_aligned = ~i_addr[0];
            SZ_WORD: w_aligned = (i_addr[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase

        w_in_range = (w_nbytes != 3'd0) && (w_end <= c_mem_limit);
        o_legal    = w_aligned && w_in_range;
        o_nbytes   = w_nbytes;
    end

endmodule
`default_nettype wire

// File: rtl/load_store_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_sequencer
//  Purpose  : Sequences byte/half/word loads and stores into single-byte,
//             big-endian memory beats and assembles extended load results.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_sequencer
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 4096,
    parameter int ADDR_W    = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_t            r_state;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [31:0]       r_resp_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_write;
    logic [31:0]       r_mem_wdata;
    logic [1:0]        r_beat;
    logic [2:0]        r_nbytes;
    logic              r_write;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [23:0]       r_wshift;
    logic [23:0]       r_acc;

    logic              w_legal;
    logic [2:0]        w_nbytes;
    logic [31:0]       w_wdata_aligned;
    logic [31:0]       w_acc_next;
    logic [31:0]       w_load_result;
    logic              w_last_beat;

    ls_req_check #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_req_check (
        .i_size   (req_size),
        .i_addr   (req_addr),
        .o_legal  (w_legal),
        .o_nbytes (w_nbytes)
    );

    // Store data is left-justified so the first beat always takes the top byte.
    always_comb begin
        case (w_nbytes)
            3'd1:    w_wdata_aligned = {req_wdata[7:0], 24'h000000};
            3'd2:    w_wdata_aligned = {req_wdata[15:0], 16'h0000};
            default: w_wdata_aligned = req_wdata;
        endcase
    end

    always_comb begin
        w_acc_next  = {r_acc, mem_rdata};
        w_last_beat = ({1'b0, r_beat} == (r_nbytes - 3'd1));
        case (r_size)
            SZ_BYTE: w_load_result = {{24{r_signed & w_acc_next[7]}},  w_acc_next[7:0]};
            SZ_HALF: w_load_result = {{16{r_signed & w_acc_next[15]}}, w_acc_next[15:0]};
            default: w_load_result = w_acc_next;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_addr   <= '0;
            r_mem_write  <= 1'b0;
            r_mem_wdata  <= '0;
            r_beat       <= '0;
            r_nbytes     <= '0;
            r_write      <= 1'b0;
            r_size       <= SZ_BYTE;
            r_signed     <= 1'b0;
            r_wshift     <= '0;
            r_acc        <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_write     <= req_write;
                        r_size      <= req_size;
                        r_signed    <= req_signed;
                        r_nbytes    <= w_nbytes;
                        r_beat      <= '0;
                        r_acc       <= '0;
                        if (w_legal) begin
                            r_state     <= ST_ACCESS;
                            r_mem_addr  <= req_addr;
                            r_mem_write <= req_write;
                            r_mem_wdata <= req_write ? {24'h000000, w_wdata_aligned[31:24]} : 32'h0;
                            r_wshift    <= w_wdata_aligned[23:0];
                        end else begin
                            // Rejected requests skip memory entirely.
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_acc <= w_acc_next[23:0];
                    if (w_last_beat) begin
                        r_state      <= ST_RESP;
                        r_mem_write  <= 1'b0;
                        r_mem_wdata  <= '0;
                        r_resp_valid <= 1'b1;
                        if (!r_write) begin
                            r_resp_rdata <= w_load_result;
                        end
                    end else begin
                        r_beat      <= r_beat + 2'd1;
                        r_mem_addr  <= r_mem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                        r_mem_wdata <= r_write ? {24'h000000, r_wshift[23:16]} : 32'h0;
                        r_wshift    <= {r_wshift[15:0], 8'h00};
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_mem_write <= 1'b0;
                    r_mem_wdata <= '0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign mem_addr   = r_mem_addr;
    assign mem_write  = r_mem_write;
    assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_sequencer
//  Purpose  : Self-checking bench: request-level reference model with a
//             per-cycle output schedule, directed cases and random traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_sequencer;

    localparam int MEM_BYTES = 4096;
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic        mem_write;
    logic [7:0]  mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    load_store_sequencer #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
        .CLK(clk), .RST(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Attached byte memory: combinational read, write on negedge.
    logic [7:0] env_mem [0:MEM_BYTES-1];
    assign mem_rdata = (mem_addr < 32'(MEM_BYTES)) ? env_mem[mem_addr[11:0]] : 8'h00;
    always @(negedge clk) begin
        if (mem_write && mem_addr < 32'(MEM_BYTES)) env_mem[mem_addr[11:0]] = mem_wdata[7:0];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          ready;
        bit          rv;
        bit          err;
        logic [31:0] rdata;
        bit          mw;
        logic [31:0] maddr;
        logic [31:0] wdata;
        bit          chk_wd;
    } exp_t;

    exp_t        sched[$];
    logic [7:0]  gm [0:MEM_BYTES-1];
    logic [31:0] m_rdata = 32'h0;
    logic [31:0] m_last_addr = 32'h0;
    bit          m_ready_cur = 1'b0;
    bit          started = 1'b0;

    task automatic model_accept(input bit w, input logic [1:0] sz, input bit s,
                                input logic [31:0] a, input logic [31:0] d);
        int     n;
        longint al, v;
        bit     legal;
        exp_t   e;
        n  = (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : (sz == SZ_W) ? 4 : 0;
        al = longint'({32'h0, a});
        legal = (n != 0) && ((al % n) == 0) && (al + n <= MEM_BYTES);
        if (!legal) begin
            e = '{ready:0, rv:1, err:1, rdata:m_rdata, mw:0, maddr:m_last_addr, wdata:0, chk_wd:1};
            sched.push_back(e);
            return;
        end
        v = 0;
        for (int k = 0; k < n; k++) begin
            logic [7:0] bt;
            bt = 8'((d >> (8 * (n - 1 - k))) & 32'hFF);
            e = '{ready:0, rv:0, err:0, rdata:m_rdata, mw:w, maddr:a + 32'(k),
                  wdata:(w ? {24'h0, bt} : 32'h0), chk_wd:w};
            sched.push_back(e);
            if (w) gm[int'(al) + k] = bt;
            v = (v << 8) | longint'(gm[int'(al) + k]);
        end
        if (s && n < 4 && (((v >> (8 * n - 1)) & 1) == 1))
            v = v | ~((longint'(1) << (8 * n)) - 1);
        if (!w) m_rdata = v[31:0];
        m_last_addr = a + 32'(n - 1);
        e = '{ready:0, rv:1, err:0, rdata:m_rdata, mw:0, maddr:m_last_addr, wdata:0, chk_wd:1};
        sched.push_back(e);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            started     = 1'b1;
            sched.delete();
            m_rdata     = 32'h0;
            m_last_addr = 32'h0;
        end else if (started && req_valid && m_ready_cur) begin
            model_accept(req_write, req_size, req_signed, req_addr, req_wdata);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (sched.size() > 0) e = sched.pop_front();
            else e = '{ready:1, rv:0, err:0, rdata:m_rdata, mw:0, maddr:m_last_addr, wdata:0, chk_wd:1};
            m_ready_cur = e.ready;
            chk("cyc_req_ready",  {31'h0, req_ready},  {31'h0, e.ready});
            chk("cyc_resp_valid", {31'h0, resp_valid}, {31'h0, e.rv});
            chk("cyc_resp_err",   {31'h0, resp_err},   {31'h0, e.err});
            chk("cyc_resp_rdata", resp_rdata, e.rdata);
            chk("cyc_mem_write",  {31'h0, mem_write},  {31'h0, e.mw});
            chk("cyc_mem_addr",   mem_addr, e.maddr);
            if (e.chk_wd) chk("cyc_mem_wdata", mem_wdata, e.wdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input bit w, input logic [1:0] sz, input bit s,
                         input logic [31:0] a, input logic [31:0] d);
        bit rdy;
        bit done;
        done = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = sz; req_signed = s;
        req_addr = a; req_wdata = d;
        for (int n = 0; n < 20 && !done; n++) begin
            rdy = req_ready;
            @(posedge clk);
            if (rdy) done = 1'b1;
            else @(negedge clk);
        end
        if (!done) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout: request at %h not accepted in 20 cycles", a);
        end
    endtask

    task automatic do_req(input bit w, input logic [1:0] sz, input bit s,
                          input logic [31:0] a, input logic [31:0] d,
                          input int exp_lat, input bit exp_err, input int exp_nwr,
                          input logic [31:0] exp_wb, input logic [31:0] exp_rd, input string nm);
        int lat, nwr;
        logic [31:0] wb, fa;
        lat = 0; nwr = 0; wb = 32'h0; fa = 32'h0;
        issue(w, sz, s, a, d);
        for (int j = 1; j <= 12 && lat == 0; j++) begin
            @(negedge clk);
            if (j == 1) req_valid = 1'b0;
            if (mem_write) begin
                if (nwr == 0) fa = mem_addr;
                nwr++;
                wb = {wb[23:0], mem_wdata[7:0]};
            end
            if (resp_valid) lat = j;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_err"}, {31'h0, resp_err}, {31'h0, exp_err});
        chk({nm, "_rdata"}, resp_rdata, exp_rd);
        chk({nm, "_nwrites"}, 32'(nwr), 32'(exp_nwr));
        chk({nm, "_wbytes"}, wb, exp_wb);
        if (nwr > 0) chk({nm, "_first_addr"}, fa, a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            gm[i] = 8'($urandom);
            env_mem[i] = gm[i];
        end
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_B;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready",      {31'h0, req_ready},  32'h1);
        chk("reset_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("reset_resp_err",   {31'h0, resp_err},   32'h0);
        chk("reset_rdata",      resp_rdata,          32'h0);
        chk("reset_mem_addr",   mem_addr,            32'h0);
        chk("reset_mem_write",  {31'h0, mem_write},  32'h0);
        chk("reset_mem_wdata",  mem_wdata,           32'h0);
        rst = 1'b0;

        do_req(1, SZ_W, 0, 32'h10,  32'hDEADBEEF, 5, 0, 4, 32'hDEADBEEF, 32'h0,        "word_store");
        do_req(0, SZ_W, 0, 32'h10,  32'h0,        5, 0, 0, 32'h0,        32'hDEADBEEF, "word_load");
        do_req(1, SZ_B, 0, 32'h20,  32'h12345680, 2, 0, 1, 32'h80,       32'hDEADBEEF, "byte_store");
        do_req(0, SZ_B, 1, 32'h20,  32'h0,        2, 0, 0, 32'h0,        32'hFFFFFF80, "byte_load_s");
        do_req(0, SZ_B, 0, 32'h20,  32'h0,        2, 0, 0, 32'h0,        32'h00000080, "byte_load_u");
        do_req(0, SZ_H, 0, 32'h21,  32'h0,        1, 1, 0, 32'h0,        32'h00000080, "half_misalign");
        do_req(0, SZ_W, 0, 32'hFFE, 32'h0,        1, 1, 0, 32'h0,        32'h00000080, "word_misalign");
        do_req(1, SZ_W, 0, 32'hFFC, 32'h01020304, 5, 0, 4, 32'h01020304, 32'h00000080, "word_store_top");
        do_req(0, SZ_W, 0, 32'hFFC, 32'h0,        5, 0, 0, 32'h0,        32'h01020304, "word_load_top");
        do_req(0, SZ_B, 0, 32'h1000,32'h0,        1, 1, 0, 32'h0,        32'h01020304, "byte_range");
        do_req(1, SZ_X, 0, 32'h0,   32'hFFFFFFFF, 1, 1, 0, 32'h0,        32'h01020304, "illegal_size");
        do_req(0, SZ_H, 1, 32'h12,  32'h0,        3, 0, 0, 32'h0,        32'hFFFFBEEF, "half_load_s");

        // Reset in the third beat of a word store.
        issue(1, SZ_W, 0, 32'h40, 32'hCAFEF00D);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_beat2_addr", mem_addr, 32'h42);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mem_write", {31'h0, mem_write}, 32'h0);
        chk("abort_ready",     {31'h0, req_ready}, 32'h1);
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            chk("abort_no_resp", {31'h0, resp_valid}, 32'h0);
            @(negedge clk);
        end
        do_req(1, SZ_W, 0, 32'h40, 32'hCAFEF00D, 5, 0, 4, 32'hCAFEF00D, 32'h0,        "restore");
        do_req(0, SZ_W, 0, 32'h40, 32'h0,        5, 0, 0, 32'h0,        32'hCAFEF00D, "reload");

        // req_valid held high with changing address while busy.
        begin
            bit rdy;
            int gap;
            gap = 0;
            issue(0, SZ_W, 0, 32'h10, 32'h0);
            for (int j = 1; j <= 12 && gap == 0; j++) begin
                @(negedge clk);
                req_addr = 32'h100 + 32'(4 * j);
                if (resp_valid) chk("held_first_rdata", resp_rdata, 32'hDEADBEEF);
                rdy = req_ready;
                @(posedge clk);
                if (rdy) gap = j;
            end
            chk("held_accept_gap", 32'(gap), 32'd6);
            @(negedge clk); req_valid = 1'b0;
            repeat (8) @(negedge clk);
        end

        // Random traffic.
        for (int r = 0; r < 300; r++) begin
            int sel, mode, n, gap;
            logic [1:0] sz;
            logic [31:0] a;
            sel = int'($urandom_range(0, 9));
            sz = (sel < 3) ? SZ_B : (sel < 6) ? SZ_H : (sel < 9) ? SZ_W : SZ_X;
            n  = (sz == SZ_B) ? 1 : (sz == SZ_H) ? 2 : (sz == SZ_W) ? 4 : 1;
            mode = int'($urandom_range(0, 3));
            case (mode)
                0:       a = 32'($urandom_range(0, MEM_BYTES - 1)) & ~32'(n - 1);
                1:       a = 32'($urandom_range(0, MEM_BYTES + 4));
                2:       a = 32'($urandom_range(MEM_BYTES - 8, MEM_BYTES + 4));
                default: a = 32'($urandom_range(0, 63)) & ~32'(n - 1);
            endcase
            issue(1'($urandom), sz, 1'($urandom), a, $urandom);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                req_valid = 1'b0;
                req_addr  = $urandom;
            end
        end
        @(negedge clk); req_valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
